// File: rtl/reg_file_bypass.sv
// Two-read/one-write register file with optional same-edge write bypass and hardwired zero entry.
// Read latency 1 cycle; no backpressure, every enabled read is accepted and answered.
module reg_file_bypass #(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_vld,
  output logic              rd0_undef,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_vld,
  output logic              rd1_undef
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  written_q, written_d;

  logic [DATA_W-1:0] rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;
  logic              rd0_vld_q, rd0_vld_d, rd1_vld_q, rd1_vld_d;
  logic              rd0_undef_q, rd0_undef_d, rd1_undef_q, rd1_undef_d;
  logic              wr_ok;

  // Writes to the hardwired zero entry are dropped before they touch storage or bypass.
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Returns {undef, data} as seen by a read sampled on this edge.
  function automatic logic [DATA_W:0] read_word(input logic [ADDR_W-1:0] addr);
    if ((ZERO_REG != 0) && (addr == '0))
      return '0;
    if ((BYPASS != 0) && wr_ok && (addr == wr_addr))
      return {1'b0, wr_data};
    return {~written_q[addr], mem_q[addr]};
  endfunction

  always_comb begin
    mem_d       = mem_q;
    written_d   = written_q;
    rd0_data_d  = rd0_data_q;
    rd0_undef_d = rd0_undef_q;
    rd0_vld_d   = rd0_en;
    rd1_data_d  = rd1_data_q;
    rd1_undef_d = rd1_undef_q;
    rd1_vld_d   = rd1_en;

    if (wr_ok) begin
      mem_d[wr_addr]     = wr_data;
      written_d[wr_addr] = 1'b1;
    end
    if (rd0_en)
      {rd0_undef_d, rd0_data_d} = read_word(rd0_addr);
    if (rd1_en)
      {rd1_undef_d, rd1_data_d} = read_word(rd1_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      written_q   <= '0;
      rd0_data_q  <= '0;
      rd0_vld_q   <= 1'b0;
      rd0_undef_q <= 1'b0;
      rd1_data_q  <= '0;
      rd1_vld_q   <= 1'b0;
      rd1_undef_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      written_q   <= written_d;
      rd0_data_q  <= rd0_data_d;
      rd0_vld_q   <= rd0_vld_d;
      rd0_undef_q <= rd0_undef_d;
      rd1_data_q  <= rd1_data_d;
      rd1_vld_q   <= rd1_vld_d;
      rd1_undef_q <= rd1_undef_d;
    end
  end

  assign rd0_data  = rd0_data_q;
  assign rd0_vld   = rd0_vld_q;
  assign rd0_undef = rd0_undef_q;
  assign rd1_data  = rd1_data_q;
  assign rd1_vld   = rd1_vld_q;
  assign rd1_undef = rd1_undef_q;

endmodule

// File: tb/tb_reg_file_bypass.sv
// Bench for reg_file_bypass: instance 0 uses ZERO_REG=0/BYPASS=1, instance 1 uses ZERO_REG=1/BYPASS=0.
// Both share inputs; expectations come from spec constants and an ordered read/write reference model.
module tb_reg_file_bypass;
  localparam int DW = 20;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd0_en, rd1_en;
  logic [AW-1:0] wr_addr, rd0_addr, rd1_addr;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] a_rd0_data, a_rd1_data, b_rd0_data, b_rd1_data;
  logic          a_rd0_vld, a_rd1_vld, b_rd0_vld, b_rd1_vld;
  logic          a_rd0_undef, a_rd1_undef, b_rd0_undef, b_rd1_undef;

  // Observed outputs indexed [instance][port]
  logic [DW-1:0] o_data  [2][2];
  logic          o_vld   [2][2];
  logic          o_undef [2][2];

  // Reference model state and expected outputs
  logic [DW-1:0] m_mem   [2][DEPTH];
  logic          m_wr    [2][DEPTH];
  logic [DW-1:0] e_data  [2][2];
  logic          e_vld   [2][2];
  logic          e_undef [2][2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(a_rd0_data), .rd0_vld(a_rd0_vld), .rd0_undef(a_rd0_undef),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(a_rd1_data), .rd1_vld(a_rd1_vld), .rd1_undef(a_rd1_undef)
  );

  reg_file_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(b_rd0_data), .rd0_vld(b_rd0_vld), .rd0_undef(b_rd0_undef),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(b_rd1_data), .rd1_vld(b_rd1_vld), .rd1_undef(b_rd1_undef)
  );

  always_comb begin
    o_data[0][0] = a_rd0_data;  o_vld[0][0] = a_rd0_vld;  o_undef[0][0] = a_rd0_undef;
    o_data[0][1] = a_rd1_data;  o_vld[0][1] = a_rd1_vld;  o_undef[0][1] = a_rd1_undef;
    o_data[1][0] = b_rd0_data;  o_vld[1][0] = b_rd0_vld;  o_undef[1][0] = b_rd0_undef;
    o_data[1][1] = b_rd1_data;  o_vld[1][1] = b_rd1_vld;  o_undef[1][1] = b_rd1_undef;
  end

  // Model of one clock edge: with bypass the write is ordered before the reads, otherwise after.
  task automatic model_edge();
    logic          en [2];
    logic [AW-1:0] ad [2];
    en[0] = rd0_en; ad[0] = rd0_addr;
    en[1] = rd1_en; ad[1] = rd1_addr;
    for (int i = 0; i < 2; i++) begin
      bit zr = (i == 1);
      bit bp = (i == 0);
      bit wr_eff = wr_en && !(zr && wr_addr == 0);
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) begin m_mem[i][k] = '0; m_wr[i][k] = 1'b0; end
        for (int p = 0; p < 2; p++) begin e_data[i][p] = '0; e_vld[i][p] = 1'b0; e_undef[i][p] = 1'b0; end
      end else begin
        if (bp && wr_eff) begin m_mem[i][wr_addr] = wr_data; m_wr[i][wr_addr] = 1'b1; end
        for (int p = 0; p < 2; p++) begin
          e_vld[i][p] = en[p];
          if (en[p]) begin
            if (zr && ad[p] == 0) begin
              e_data[i][p] = '0; e_undef[i][p] = 1'b0;
            end else begin
              e_data[i][p] = m_mem[i][ad[p]]; e_undef[i][p] = !m_wr[i][ad[p]];
            end
          end
        end
        if (!bp && wr_eff) begin m_mem[i][wr_addr] = wr_data; m_wr[i][wr_addr] = 1'b1; end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; rd0_en = 0; rd1_en = 0;
    wr_addr = '0; wr_data = '0; rd0_addr = '0; rd1_addr = '0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        n_tests++;
        if (o_data[i][p] !== '0 || o_vld[i][p] !== 1'b0 || o_undef[i][p] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_state inst%0d port%0d: got data=%h vld=%b undef=%b, want 0/0/0",
                   i, p, o_data[i][p], o_vld[i][p], o_undef[i][p]);
        end
      end
    idle(); rd0_en = 1; rd0_addr = 5; rd1_en = 1; rd1_addr = 15; tick();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        n_tests++;
        if (o_data[i][p] !== '0 || o_vld[i][p] !== 1'b1 || o_undef[i][p] !== 1'b1) begin
          n_fail++;
          $display("FAIL read_after_reset inst%0d port%0d: got data=%h vld=%b undef=%b, want 0/1/1",
                   i, p, o_data[i][p], o_vld[i][p], o_undef[i][p]);
        end
      end
  endtask

  task automatic test_write_read();
    idle(); wr_en = 1; wr_addr = 3; wr_data = 20'h12345; tick();
    idle(); rd0_en = 1; rd0_addr = 3; tick();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (o_data[i][0] !== 20'h12345 || o_undef[i][0] !== 1'b0 || o_vld[i][0] !== 1'b1) begin
        n_fail++;
        $display("FAIL write_read inst%0d: got data=%h undef=%b vld=%b, want 12345/0/1",
                 i, o_data[i][0], o_undef[i][0], o_vld[i][0]);
      end
    end
    idle(); tick();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (o_data[i][0] !== 20'h12345 || o_vld[i][0] !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold inst%0d: got data=%h vld=%b, want 12345/0", i, o_data[i][0], o_vld[i][0]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    idle(); wr_en = 1; wr_addr = 7; wr_data = 20'h00AAA; tick();
    idle(); wr_en = 1; wr_addr = 7; wr_data = 20'h0BBBB;
    rd0_en = 1; rd0_addr = 7; rd1_en = 1; rd1_addr = 7; tick();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        want = (i == 0) ? 20'h0BBBB : 20'h00AAA;
        n_tests++;
        if (o_data[i][p] !== want || o_undef[i][p] !== 1'b0) begin
          n_fail++;
          $display("FAIL same_edge_rw inst%0d port%0d: got data=%h undef=%b, want %h/0",
                   i, p, o_data[i][p], o_undef[i][p], want);
        end
      end
    idle(); rd0_en = 1; rd0_addr = 7; rd1_en = 1; rd1_addr = 7; tick();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        n_tests++;
        if (o_data[i][p] !== 20'h0BBBB) begin
          n_fail++;
          $display("FAIL after_bypass inst%0d port%0d: got %h, want 0bbbb", i, p, o_data[i][p]);
        end
      end
  endtask

  task automatic test_zero_reg();
    idle(); wr_en = 1; wr_addr = 0; wr_data = 20'hFFFFF; tick();
    idle(); rd0_en = 1; rd0_addr = 0; tick();
    n_tests++;
    if (o_data[0][0] !== 20'hFFFFF || o_undef[0][0] !== 1'b0) begin
      n_fail++;
      $display("FAIL plain_reg0 inst0: got data=%h undef=%b, want fffff/0", o_data[0][0], o_undef[0][0]);
    end
    n_tests++;
    if (o_data[1][0] !== '0 || o_undef[1][0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg0 inst1: got data=%h undef=%b, want 0/0", o_data[1][0], o_undef[1][0]);
    end
    idle(); wr_en = 1; wr_addr = 0; wr_data = 20'h13579; rd1_en = 1; rd1_addr = 0; tick();
    n_tests++;
    if (o_data[1][1] !== '0 || o_undef[1][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg0_during_write inst1: got data=%h undef=%b, want 0/0", o_data[1][1], o_undef[1][1]);
    end
  endtask

  task automatic test_reset_clears();
    idle(); wr_en = 1; wr_addr = 9; wr_data = 20'h00055; tick();
    idle(); rst = 1; wr_en = 1; wr_addr = 10; wr_data = 20'h00077; rd0_en = 1; rd0_addr = 9; tick();
    idle(); rd0_en = 1; rd0_addr = 9; rd1_en = 1; rd1_addr = 10; tick();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        n_tests++;
        if (o_data[i][p] !== '0 || o_undef[i][p] !== 1'b1 || o_vld[i][p] !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_clears inst%0d port%0d: got data=%h undef=%b vld=%b, want 0/1/1",
                   i, p, o_data[i][p], o_undef[i][p], o_vld[i][p]);
        end
      end
  endtask

  task automatic test_random_sweep();
    int perm [DEPTH];
    int j, t, errs;
    for (int k = 0; k < DEPTH; k++) perm[k] = k;
    for (int k = DEPTH - 1; k > 0; k--) begin
      j = $urandom_range(k, 0); t = perm[k]; perm[k] = perm[j]; perm[j] = t;
    end
    for (int c = 0; c < DEPTH + 200; c++) begin
      idle();
      if (c < DEPTH) begin
        wr_en = 1; wr_addr = AW'(perm[c]);
        wr_data = {wr_addr, 16'($urandom)};
      end else begin
        wr_en = ($urandom_range(3, 0) != 0);
        wr_addr = AW'($urandom);
        wr_data = DW'($urandom);
      end
      rd0_en = ($urandom_range(4, 0) != 0);
      rd1_en = ($urandom_range(4, 0) != 0);
      rd0_addr = ($urandom_range(2, 0) == 0) ? wr_addr : AW'($urandom);
      rd1_addr = ($urandom_range(2, 0) == 0) ? wr_addr : AW'($urandom);
      tick();
      errs = 0;
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) begin
          n_tests++;
          if (o_data[i][p] !== e_data[i][p] || o_vld[i][p] !== e_vld[i][p] || o_undef[i][p] !== e_undef[i][p]) begin
            n_fail++;
            if (errs < 4)
              $display("FAIL random_sweep cyc%0d inst%0d port%0d: got %h/%b/%b, want %h/%b/%b",
                       c, i, p, o_data[i][p], o_vld[i][p], o_undef[i][p],
                       e_data[i][p], e_vld[i][p], e_undef[i][p]);
            errs++;
          end
        end
    end
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_reset_clears();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
